// File: rtl/fpga_ssp_pkg.sv
// Shared types and defaults for the FPGA-to-ARM SSP transmit path.
// Holds the serializer state encoding and the bit-counter width helper.

package fpga_ssp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ssp_state_e;

    localparam int SSP_WORD_W     = 16;
    localparam int SSP_CLK_DIV    = 4;
    localparam int SSP_FIFO_DEPTH = 4;

    // Width able to hold WORD_W-1, never narrower than one bit.
    function automatic int ssp_cnt_w(input int word_w);
        return (word_w > 2) ? $clog2(word_w) : 1;
    endfunction

endpackage

// File: rtl/ssp_tx_fifo.sv
// Synchronous FIFO for the SSP transmitter: push/pop on i_pck0, data out is the head entry (0-cycle read).
// Full/empty are registered; a push while full is ignored even if a pop happens in the same cycle.

module ssp_tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             i_pck0,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    assign w_push      = i_push && !r_full;
    assign w_pop       = i_pop && !r_empty;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge i_pck0) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_pck0) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/ssp_tx_serializer.sv
// MSB-first SSP transmitter (ssp_clk = pck0/(2*CLK_DIV)); push-to-frame 2..2*CLK_DIV+1 cycles, in_ready low while FIFO full.
// Define SSP_TX_PARITY_EN to append an even-parity bit period after each word's LSB.

module ssp_tx_serializer
    import fpga_ssp_pkg::*;
#(
    parameter int WORD_W     = SSP_WORD_W,
    parameter int CLK_DIV    = SSP_CLK_DIV,
    parameter int FIFO_DEPTH = SSP_FIFO_DEPTH
) (
    input  logic              pck0,
    input  logic              rst,
    input  logic              enable,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ssp_clk,
    output logic              ssp_frame,
    output logic              ssp_din,
    output logic              busy,
    output logic              overflow
);

    localparam int CNT_W = ssp_cnt_w(WORD_W);
    localparam int DIV_W = $clog2(CLK_DIV);

    ssp_state_e        r_state;
    ssp_state_e        w_state_nxt;
    logic [WORD_W-1:0] r_shreg;
    logic [WORD_W-1:0] w_shreg_nxt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic              r_frame;
    logic              w_frame_nxt;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_ssp_clk;
    logic              r_overflow;

    logic              w_tc;
    logic              w_fall_ev;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_load;
    logic              w_can_load;
    logic [WORD_W-1:0] w_fifo_dout;

`ifdef SSP_TX_PARITY_EN
    logic              r_par;
    logic              w_par_nxt;
    logic              r_par_sent;
    logic              w_par_sent_nxt;
`endif

    ssp_tx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_pck0  (pck0),
        .i_rst   (rst),
        .i_push  (in_valid),
        .i_din   (in_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_tc       = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_fall_ev  = w_tc && r_ssp_clk;
    assign w_can_load = enable && !w_empty;

    always_ff @(posedge pck0) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_ssp_clk  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_tc) begin
                r_div_cnt <= '0;
                r_ssp_clk <= ~r_ssp_clk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            r_overflow <= r_overflow | (in_valid & w_full);
        end
    end

    always_ff @(posedge pck0) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_frame    <= 1'b0;
`ifdef SSP_TX_PARITY_EN
            r_par      <= 1'b0;
            r_par_sent <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_frame    <= w_frame_nxt;
`ifdef SSP_TX_PARITY_EN
            r_par      <= w_par_nxt;
            r_par_sent <= w_par_sent_nxt;
`endif
        end
    end

    // ssp_din is the shift register MSB, so clearing the register idles the line low.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_frame_nxt   = r_frame;
        w_pop         = 1'b0;
        w_load        = 1'b0;
`ifdef SSP_TX_PARITY_EN
        w_par_nxt      = r_par;
        w_par_sent_nxt = r_par_sent;
`endif
        if (w_fall_ev) begin
            case (r_state)
                IDLE: begin
                    if (w_can_load) begin
                        w_load = 1'b1;
                    end else begin
                        w_shreg_nxt = '0;
                        w_frame_nxt = 1'b0;
                    end
                end
                SHIFT: begin
                    if (r_bit_cnt != '0) begin
                        w_shreg_nxt   = {r_shreg[WORD_W-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
                        w_frame_nxt   = 1'b0;
                    end
`ifdef SSP_TX_PARITY_EN
                    else if (!r_par_sent) begin
                        w_shreg_nxt    = {r_par, {(WORD_W-1){1'b0}}};
                        w_par_sent_nxt = 1'b1;
                        w_frame_nxt    = 1'b0;
                    end
`endif
                    else if (w_can_load) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_shreg_nxt = '0;
                        w_frame_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_shreg_nxt = '0;
                    w_frame_nxt = 1'b0;
                end
            endcase
        end
        if (w_load) begin
            w_pop         = 1'b1;
            w_shreg_nxt   = w_fifo_dout;
            w_bit_cnt_nxt = CNT_W'(WORD_W - 1);
            w_frame_nxt   = 1'b1;
            w_state_nxt   = SHIFT;
`ifdef SSP_TX_PARITY_EN
            w_par_nxt      = ^w_fifo_dout;
            w_par_sent_nxt = 1'b0;
`endif
        end
    end

    assign in_ready  = !w_full;
    assign ssp_clk   = r_ssp_clk;
    assign ssp_frame = r_frame;
    assign ssp_din   = r_shreg[WORD_W-1];
    assign busy      = (r_state == SHIFT) || !w_empty;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Directed bench for ssp_tx_serializer (WORD_W=16, CLK_DIV=4, FIFO_DEPTH=4).
// Bits are captured at each ssp_clk rise, sampled on the pck0 falling edge.

module tb_ssp_tx_serializer;

`ifdef SSP_TX_PARITY_EN
    localparam int BITS = 17;
`else
    localparam int BITS = 16;
`endif

    logic        pck0 = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ssp_clk;
    logic        ssp_frame;
    logic        ssp_din;
    logic        busy;
    logic        overflow;

    int           n_chk = 0;
    int           n_err = 0;
    logic [127:0] c_bits;
    logic [127:0] c_frm;
    int           c_fhi;
    int           c_busy;

    always #5 pck0 = ~pck0;

    ssp_tx_serializer #(
        .WORD_W     (16),
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .pck0      (pck0),
        .rst       (rst),
        .enable    (enable),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ssp_clk   (ssp_clk),
        .ssp_frame (ssp_frame),
        .ssp_din   (ssp_din),
        .busy      (busy),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected serial stream for one more word appended to acc.
    function automatic logic [127:0] app_bits(input logic [127:0] acc, input logic [15:0] w);
`ifdef SSP_TX_PARITY_EN
        return {acc[110:0], w, ^w};
`else
        return {acc[111:0], w};
`endif
    endfunction

    function automatic logic [127:0] app_frm(input logic [127:0] acc);
`ifdef SSP_TX_PARITY_EN
        return {acc[110:0], 1'b1, 16'd0};
`else
        return {acc[111:0], 1'b1, 15'd0};
`endif
    endfunction

    task automatic push(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge pck0);
        #1;
        in_valid = 1'b0;
    endtask

    // Capture n bits at ssp_clk rises; with need_frame, start at the first framed bit.
    task automatic collect(input int n, input bit need_frame);
        logic prev;
        int   got;
        bit   started;
        prev    = ssp_clk;
        got     = 0;
        started = !need_frame;
        c_bits  = '0;
        c_frm   = '0;
        c_fhi   = 0;
        c_busy  = 0;
        for (int k = 0; k < n * 8 + 64 && got < n; k++) begin
            @(negedge pck0);
            c_fhi  += int'(ssp_frame);
            c_busy += int'(busy);
            if (ssp_clk && !prev) begin
                if (ssp_frame) started = 1'b1;
                if (started) begin
                    c_bits = {c_bits[126:0], ssp_din};
                    c_frm  = {c_frm[126:0], ssp_frame};
                    got++;
                end
            end
            prev = ssp_clk;
        end
        check("collect_cnt", 128'(got), 128'(n));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2000; k++) begin
            @(negedge pck0);
            if (!busy) break;
            c_busy++;
        end
        check("idle_reached", 128'(busy), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [127:0] e_bits;
        logic [127:0] e_frm;
        logic [15:0]  first5_rest;
        int           bad;

        rst      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge pck0);
        #1;
        check("rst_ssp_clk", 128'(ssp_clk), 128'(0));
        check("rst_frame", 128'(ssp_frame), 128'(0));
        check("rst_din", 128'(ssp_din), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_overflow", 128'(overflow), 128'(0));
        rst    = 1'b0;
        enable = 1'b1;
        repeat (5) @(posedge pck0);
        #1;

        // Test 1: single word
        push(16'hA5C3);
        collect(BITS, 1'b1);
        check("t1_bits", c_bits, app_bits('0, 16'hA5C3));
        check("t1_word", 128'(c_bits[BITS-1 -: 16]), 128'(16'hA5C3));
        check("t1_frames", c_frm, app_frm('0));
        check("t1_frame_len", 128'(c_fhi), 128'(8));
        wait_idle();
        check("t1_busy_len", 128'(c_busy >= BITS * 8 + 1 && c_busy <= BITS * 8 + 8), 128'(1));
        bad = 0;
        repeat (20) begin
            @(negedge pck0);
            if (ssp_din || ssp_frame) bad++;
        end
        check("t1_idle_line", 128'(bad), 128'(0));

        // Test 2: back-to-back words
        push(16'hFFFF);
        push(16'h0001);
        collect(2 * BITS, 1'b1);
        check("t2_bits", c_bits, app_bits(app_bits('0, 16'hFFFF), 16'h0001));
        check("t2_frames", c_frm, app_frm(app_frm('0)));
        wait_idle();

        // Test 3: fill while disabled, overflow
        check("t3_ovf_before", 128'(overflow), 128'(0));
        enable = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_data  = 16'(i * 16'h1111);
            in_valid = 1'b1;
            @(posedge pck0);
            #1;
        end
        in_valid = 1'b0;
        check("t3_in_ready", 128'(in_ready), 128'(0));
        check("t3_overflow", 128'(overflow), 128'(1));
        repeat (10) @(posedge pck0);
        #1;
        check("t3_ovf_sticky", 128'(overflow), 128'(1));
        check("t3_busy_held", 128'(busy), 128'(1));
        check("t3_din_quiet", 128'(ssp_din), 128'(0));
        enable = 1'b1;
        collect(4 * BITS, 1'b1);
        e_bits = app_bits(app_bits(app_bits(app_bits('0, 16'h1111), 16'h2222), 16'h3333), 16'h4444);
        e_frm  = app_frm(app_frm(app_frm(app_frm('0))));
        check("t3_bits", c_bits, e_bits);
        check("t3_frames", c_frm, e_frm);
        wait_idle();
        check("t3_in_ready_after", 128'(in_ready), 128'(1));

        // Test 4: drop enable mid-word
        push(16'h8001);
        push(16'hAAAA);
        collect(5, 1'b1);
        first5_rest = {11'd0, c_bits[4:0]};
        enable = 1'b0;
        collect(11, 1'b0);
        first5_rest = {first5_rest[4:0], c_bits[10:0]};
        check("t4_word", 128'(first5_rest), 128'(16'h8001));
        collect(2, 1'b0);
        check("t4_tail_bits", c_bits, 128'(0));
        check("t4_tail_frames", c_frm, 128'(0));
        check("t4_busy", 128'(busy), 128'(1));
        enable = 1'b1;
        collect(BITS, 1'b1);
        check("t4_queued", c_bits, app_bits('0, 16'hAAAA));
        wait_idle();

        // Test 5: reset mid-word
        push(16'h1234);
        push(16'h5678);
        collect(8, 1'b1);
        check("t5_first8", 128'(c_bits[7:0]), 128'(8'h12));
        check("t5_ovf_pre", 128'(overflow), 128'(1));
        rst = 1'b1;
        @(posedge pck0);
        #1;
        rst = 1'b0;
        check("t5_ssp_clk", 128'(ssp_clk), 128'(0));
        check("t5_frame", 128'(ssp_frame), 128'(0));
        check("t5_din", 128'(ssp_din), 128'(0));
        check("t5_in_ready", 128'(in_ready), 128'(1));
        check("t5_overflow", 128'(overflow), 128'(0));
        check("t5_busy", 128'(busy), 128'(0));
        bad = 0;
        repeat (40) begin
            @(negedge pck0);
            if (ssp_din || ssp_frame || busy) bad++;
        end
        check("t5_no_resume", 128'(bad), 128'(0));

        // Test 6: parity bit (or plain back-to-back framing without it)
        push(16'h0007);
        push(16'h0003);
`ifdef SSP_TX_PARITY_EN
        collect(34, 1'b1);
        check("t6_bits", c_bits, {94'd0, 16'h0007, 1'b1, 16'h0003, 1'b0});
        check("t6_frames", c_frm, {94'd0, 1'b1, 16'd0, 1'b1, 16'd0});
`else
        collect(32, 1'b1);
        check("t6_bits", c_bits, {96'd0, 16'h0007, 16'h0003});
        check("t6_frames", c_frm, {96'd0, 32'h8000_8000});
`endif
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ssp_tx_serializer.md
Name: ssp_tx_serializer

Overview:
Sends demodulated HF samples from the FPGA to the ARM over the SSP link (ssp_clk, ssp_frame, ssp_din). This is the FPGA-to-ARM direction, the counterpart of the configuration-word receiver from the ARM. Mode blocks push parallel words through a small FIFO. The block serializes each word MSB-first on a divided SSP clock and marks each word's first bit with a frame pulse.

Parameters:
WORD_W, 16, bits per SSP word (range 4..32)
CLK_DIV, 4, pck0 cycles per ssp_clk half-period (>=2); ssp_clk period = 2*CLK_DIV
FIFO_DEPTH, 4, input FIFO entries (power of two, >=2)

Ports:
pck0  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  1 = start new words; 0 = finish the current word, then idle
in_data  in  WORD_W  word to transmit
in_valid  in  1  in_data is valid
in_ready  out  1  FIFO can accept (= !full, registered)
ssp_clk  out  1  SSP bit clock to the ARM
ssp_frame  out  1  high for exactly the first bit period of each word
ssp_din  out  1  serial data to the ARM, MSB first
busy  out  1  word in flight or FIFO non-empty
overflow  out  1  sticky: in_valid seen while in_ready=0

Behaviour:
- Reset values: ssp_clk=0, ssp_frame=0, ssp_din=0, in_ready=1, busy=0, overflow=0. Reset also clears the FIFO, state=IDLE, and the divider and bit counters.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
  - At terminal count, ssp_clk toggles.
  - If ssp_clk=1 at that point, the event is a falling event (fall_ev).
  - ssp_clk runs freely after reset, independent of enable.
- Timing: ssp_din and ssp_frame change only on the pck0 edge where ssp_clk falls. They are stable for a full 2*CLK_DIV period around each ssp_clk rising edge, which is the ARM sampling edge.
- FIFO: push when in_valid && in_ready. in_ready is computed from the registered full flag.
  - When full, a same-cycle pop does not admit a push (no bypass).
  - in_valid && !in_ready sets overflow; the word is dropped.
- FSM states: IDLE, SHIFT.
  - IDLE, fall_ev && enable && FIFO non-empty: pop into shreg; ssp_din=shreg MSB; ssp_frame=1; bit_cnt=WORD_W-1; go to SHIFT.
  - IDLE, otherwise: ssp_din=0, ssp_frame=0.
  - SHIFT, fall_ev && bit_cnt>0: shift left; ssp_din=next bit; ssp_frame=0; bit_cnt-=1.
  - SHIFT, fall_ev && bit_cnt==0 && enable && FIFO non-empty: load the next word back-to-back with no gap; ssp_frame=1.
  - SHIFT, fall_ev && bit_cnt==0, otherwise: go to IDLE; ssp_din=0; ssp_frame=0.
- Deasserting enable mid-word does not truncate the word. The FIFO contents are retained.
- Latency: a push into an empty FIFO while IDLE gives ssp_frame high between 2 and 2*CLK_DIV+1 pck0 cycles later.
- busy = (state==SHIFT) || !empty.
- Reset mid-word: output returns to its reset value on the next edge. There is no partial-word completion.

Optional Feature:
SSP_TX_PARITY_EN:
- Defined: after the LSB, one extra bit period carries even parity of the word (XOR of all WORD_W bits). ssp_frame stays 0 during it, and the next word's frame follows immediately. The word occupies WORD_W+1 bit periods.
- Undefined: no parity bit; WORD_W bit periods per word; parity logic is absent.

Decomposition:
- Package fpga_ssp_pkg:
  - state enum (IDLE, SHIFT)
  - default constants SSP_WORD_W=16, SSP_CLK_DIV=4, SSP_FIFO_DEPTH=4
  - function for the bit counter width (clog2)
- Sub-module ssp_tx_fifo: synchronous FIFO with push, pop, full, empty and pointer wrap. Depth and width are parameterized.

Test Plan:
- Test 1: reset, then push 16'hA5C3 (WORD_W=16, CLK_DIV=4) -> ssp_frame high for 8 pck0 cycles; ssp_din at successive ssp_clk rises = 1010_0101_1100_0011; busy falls after 128 cycles; ssp_din=0 afterwards.
- Test 2: push 16'hFFFF then 16'h0001 back-to-back -> second frame pulse follows the 16th bit with no gap; 32 contiguous bit periods.
- Test 3: hold in_valid with enable=0 for 6 pushes (depth 4) -> in_ready=0 after 4 accepted; overflow=1 and stays 1; after enable=1, exactly 4 words are sent in order.
- Test 4: drop enable after bit 5 of 16'h8001 -> word completes (LSB=1), then IDLE; the queued word stays in the FIFO; busy stays 1.
- Test 5: assert rst for 1 cycle at bit 8 -> next cycle ssp_clk=0, ssp_frame=0, ssp_din=0, in_ready=1, overflow=0; nothing resumes.
- Test 6: with SSP_TX_PARITY_EN, send 16'h0007 -> a 17th bit period carries 1; the next frame starts right after it.
